spi_bus_master_arb: RTL
=======================

Name: spi_bus_master_arb

Overview:
- Single SPI master that drives the shared sclk/mosi/cs bus to the board's addressed SPI slave registers (write-type output registers and read-type input ports).
- Arbitrates between two internal requesters with round-robin priority.
- Sequences one frame per request: 8-bit header (bit7 = r/w, bits6:0 = slave address, MSB first), then the data phase.
- Returns read data and a done pulse to the requester.

Parameters:
- NBIT, 8, data-phase width in bits (1..32).
- DIV, 4, sclk half-period in clk cycles (min 4, so slave 3-stage edge detectors see each edge).
- CS_SETUP, 4, clk cycles from cs low to first sclk rise, and from last sclk fall to cs high (min 4).
- CS_IDLE, 4, minimum clk cycles cs held high between frames (min 4).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- r0_req  in  1  requester 0 request; held high with fields stable until r0_done
- r0_rw  in  1  1 = write to slave, 0 = read from slave
- r0_adr  in  7  slave address
- r0_wdata  in  NBIT  write data
- r0_done  out  1  one-cycle completion pulse
- r1_req, r1_rw, r1_adr, r1_wdata, r1_done  same as r0_* for requester 1
- rdata  out  NBIT  read result, valid with done, held until next read completes
- busy  out  1  high from grant until return to IDLE
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs  out  1  chip select, active low

Behaviour:
- Reset (rst=0, async): cs=1, sclk=0, mosi=0, r0_done=r1_done=0, rdata=0, busy=0, FSM=IDLE, RR pointer favours r0.
- Reset asserted mid-frame: cs rises immediately; no done is issued; a request still held after reset is restarted from scratch.
- Arbitration happens only in IDLE:
  - One req high: grant it.
  - Both high: grant the requester not granted last.
  - Grant latches rw/adr/wdata into a shift register; busy=1 on the next cycle.
- FSM states and transitions:
  - IDLE -> SETUP on grant.
  - SETUP: cs=0, sclk=0, mosi = header bit7 (= rw), CS_SETUP cycles -> SHIFT.
  - SHIFT runs P sclk periods, P = 8+NBIT for write and 8+NBIT+1 for read.
  - SHIFT -> HOLD after the last period's low half ends (sclk low).
  - HOLD: cs=0, sclk=0, CS_SETUP cycles -> GAP.
  - GAP: cs=1, CS_IDLE cycles -> IDLE.
  - done for the granted requester pulses in the first GAP cycle. For reads, rdata updates in that same cycle.
- sclk period timing: each period is 2*DIV clk cycles, DIV cycles high then DIV cycles low.
  - The first rise occurs at the end of SETUP.
- mosi updates on each sclk fall (data is stable across the rise).
- mosi bit sequence:
  - Header: rw, adr[6], ..., adr[0].
  - Write data phase: wdata[NBIT-1] down to wdata[0].
  - Read data phase: mosi=0.
- miso sampling:
  - Sampled on the last clk cycle of each high half, during data-phase periods 2..NBIT+1 only.
  - Shifted into rdata_shift MSB first.
  - Period 1 of the read data phase is a dummy; the slave presents its first bit after that period's falling edge.
- Header/data gap: no extra gap is required. The low half after the 8th rise (>=4 cycles) gives the slave time to decode the header.
- Back-to-back:
  - A requester keeping req high after done is treated as a new request at the next IDLE arbitration.
  - cs is always high for >= CS_IDLE cycles between frames.
- req dropped before done: the frame still completes and done still pulses. Fields were latched at grant, so later changes are ignored.
- Counters:
  - Clock-divide counter is ceil(log2(DIV)) bits.
  - Bit counter is 6 bits and wraps to 0 only on SHIFT exit.

Test Plan:
- Write: NBIT=8, DIV=4, r0 write adr=0x05 wdata=0xA5 -> 16 sclk rises, mosi bits 0x85 then 0xA5, write slave model output=0xA5, r0_done one pulse, r1_done=0.
- Read: r1 read adr=0x02, slave input port=0x3C -> header 0x02, 17 sclk rises, rdata=0x3C with r1_done, rdata unchanged until next read.
- Arbitration: r0_req and r1_req high in the same cycle, twice -> frame order r0, r1; then with both still high -> r0, r1 alternating; never two consecutive grants to one requester while the other waits.
- Timing: measure cs-fall to first sclk rise >= 4 clk, last fall to cs-rise >= 4 clk, cs high between back-to-back frames >= CS_IDLE, sclk high/low = DIV each.
- Reset mid-frame: assert rst=0 after 5th sclk rise of a write -> cs=1, sclk=0 in the same cycle, no done; release with req still high -> a complete frame is restarted and done pulses once.
- Address mismatch: write to adr=0x07 with slave at 0x05 -> slave output unchanged, master still completes 16 rises and pulses done.

Source files
------------

// File: rtl/spi_bus_master_arb.sv
// SPI bus master shared by two internal requesters.
// Round-robin arbitration picks one request in IDLE. Each frame is an 8-bit
// header {rw, adr[6:0]} followed by the data phase. Reads add one dummy
// period before the slave returns data.
//
// Requester handshake: reqN acts as "valid". Its rw/adr/wdata fields must be
// stable while reqN is high. The grant in IDLE is the implicit "ready": the
// fields are copied into the frame registers on that cycle. doneN is a
// single-cycle completion strobe in the first GAP cycle. A read result is
// presented on rdata in that same cycle and holds until the next read
// completes.
module spi_bus_master_arb #(
  parameter int NBIT     = 8,
  parameter int DIV      = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req,
  input  logic            r0_rw,
  input  logic [6:0]      r0_adr,
  input  logic [NBIT-1:0] r0_wdata,
  output logic            r0_done,
  input  logic            r1_req,
  input  logic            r1_rw,
  input  logic [6:0]      r1_adr,
  input  logic [NBIT-1:0] r1_wdata,
  output logic            r1_done,
  output logic [NBIT-1:0] rdata,
  output logic            busy,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            cs,
  output logic [2:0]      state_dbg
);

  localparam int SW   = 8 + NBIT;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CMAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
  localparam int CW   = $clog2(CMAX + 1);

  // IDLE is encoded as 0 so the debug port reads 0 whenever the bus is free.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   div_cnt;
  logic [5:0]      bit_cnt;
  logic            sclk_r;
  logic [SW-1:0]   sh;
  logic [NBIT-1:0] rshift;
  logic            rw_q;
  logic            gnt_q;
  logic            last_q;

  logic            grant;
  logic            gnt_id;
  logic            sel_rw;
  logic [6:0]      sel_adr;
  logic [NBIT-1:0] sel_data;
  logic            setup_end;
  logic            hold_end;
  logic            gap_end;
  logic            div_end;
  logic            fall_evt;
  logic            low_end;
  logic            last_period;
  logic            sample_evt;
  logic [5:0]      p_last;

  // Arbitration: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    gnt_id   = (r0_req && r1_req) ? ~last_q : r1_req;
    sel_rw   = gnt_id ? r1_rw  : r0_rw;
    sel_adr  = gnt_id ? r1_adr : r0_adr;
    sel_data = '0;
    if (sel_rw) sel_data = gnt_id ? r1_wdata : r0_wdata;
  end

  assign grant     = (state == S_IDLE) && (r0_req || r1_req);
  assign setup_end = (cnt == CW'(CS_SETUP - 1));
  assign hold_end  = (cnt == CW'(CS_SETUP - 1));
  assign gap_end   = (cnt == CW'(CS_IDLE - 1));
  assign div_end   = (div_cnt == DW'(DIV - 1));
  // Index of the final sclk period: writes have 8+NBIT periods, reads one more.
  assign p_last      = rw_q ? 6'(SW - 1) : 6'(SW);
  assign fall_evt    = (state == S_SHIFT) && sclk_r && div_end;
  assign low_end     = (state == S_SHIFT) && !sclk_r && div_end;
  assign last_period = (bit_cnt == p_last);
  // Read data is taken at the end of the high half of periods 9..8+NBIT;
  // period 8 is the dummy while the slave prepares its first bit.
  assign sample_evt  = (state == S_SHIFT) && !rw_q && sclk_r && div_end &&
                       (bit_cnt >= 6'd9) && (bit_cnt <= 6'(SW));

  assign sclk      = sclk_r;
  assign mosi      = sh[SW-1];
  assign state_dbg = state;

  // State register; cs and busy are registered copies of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cs    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cs    <= !((state_nx == S_SETUP) || (state_nx == S_SHIFT) || (state_nx == S_HOLD));
      busy  <= (state_nx != S_IDLE);
    end
  end

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant) state_nx = S_SETUP;
      S_SETUP: if (setup_end) state_nx = S_SHIFT;
      S_SHIFT: if (low_end && last_period) state_nx = S_HOLD;
      S_HOLD:  if (hold_end) state_nx = S_GAP;
      S_GAP:   if (gap_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame datapath: phase counters, sclk generation, shift registers, done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk_r  <= 1'b0;
      sh      <= '0;
      rshift  <= '0;
      rw_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata   <= '0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (grant) begin
            gnt_q  <= gnt_id;
            last_q <= gnt_id;
            rw_q   <= sel_rw;
            sh     <= {sel_rw, sel_adr, sel_data};
            rshift <= '0;
          end
        end
        S_SETUP: begin
          if (setup_end) begin
            cnt     <= '0;
            sclk_r  <= 1'b1;
            div_cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          div_cnt <= div_end ? '0 : div_cnt + DW'(1);
          if (fall_evt) begin
            sclk_r <= 1'b0;
            sh     <= sh << 1;
          end
          if (low_end) begin
            if (last_period) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              sclk_r  <= 1'b1;
            end
          end
          if (sample_evt) rshift <= (rshift << 1) | NBIT'(miso);
        end
        S_HOLD: begin
          if (hold_end) begin
            cnt     <= '0;
            r0_done <= ~gnt_q;
            r1_done <= gnt_q;
            if (!rw_q) rdata <= rshift;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          cnt <= gap_end ? '0 : cnt + CW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
